hazard_sb: RTL and testbench



---
 rtl/hazard_sb.sv | 167 ++++++++++++++++
 tb/tb_hazard_sb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// hazard_sb -- hazard scoreboard for a five-stage pipeline with an optional
// multi-cycle multiply/divide unit.
//
// Optional feature: define HAZARD_MDU_EN to enable multiply/divide tracking
// (MDU busy counter, MDU stall, MDU start acceptance). Without it the MDU
// ports are present but ignored and MduBusy is tied low.
//
// Parameters
//   REG_AW   register-specifier width
//   MDU_LAT  multiply/divide latency in cycles (legal range 2..255)
//   CNT_W    stall-counter width
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   RsD, RtD, RsE, RtE              source specifiers in D and E
//   WriteRegE/M/W, RegWriteE/M/W    destination specifiers and write enables
//   MemtoRegE, MemtoRegM            stage holds a load
//   BranchD                         D holds a branch
//   DmemReqM, DmemReadyM            data-memory request / completion in M
//   MduStartE, MduD, HiLoReadD      MDU op in E, MDU op in D, HI/LO read in D
//   ForwardAE/BE/AD/BD              forwarding selects (10 = M, 01 = W, 00 = RF)
//   StallF/D/E/M, FlushE, FlushW    pipeline hold and bubble controls
//   MduBusy                         MDU operation in progress
//   StallCount                      saturating count of cycles with StallF high
module hazard_sb #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              DmemReqM,
  input  logic              DmemReadyM,
  input  logic              MduStartE,
  input  logic              MduD,
  input  logic              HiLoReadD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [1:0]        ForwardAD,
  output logic [1:0]        ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MduBusy,
  output logic [CNT_W-1:0]  StallCount
);

  // Down-counter wide enough to hold MDU_LAT.
  localparam int             MCW      = $clog2(MDU_LAT + 1);
  localparam logic [MCW-1:0] MDU_LOAD = MCW'(MDU_LAT);

  // M stage has priority over W; register 0 is never forwarded.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wrM,
    input logic              rwM,
    input logic [REG_AW-1:0] wrW,
    input logic              rwW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (rwM && (src == wrM))      sel = 2'b10;
      else if (rwW && (src == wrW)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE = fwdSel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardBE = fwdSel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardAD = fwdSel(RsD, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardBD = fwdSel(RtD, WriteRegM, RegWriteM, WriteRegW, RegWriteW);

  logic loadStall;
  logic branchStall;
  logic memStall;
  logic mduStall;

  assign loadStall = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));

  // A branch resolves in D, so it must wait for an ALU result still in E or a
  // load result still in M.
  assign branchStall = BranchD &&
    ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
     (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  assign memStall = DmemReqM && !DmemReadyM;

  // A memory stall freezes the whole front of the pipe and drains W; it takes
  // precedence over the D-stage stalls, which instead bubble E.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (loadStall || branchStall || mduStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_MDU_EN
  logic [MCW-1:0] mduCnt;
  logic           mduAccept;

  // A start held in a stalled E stage is not taken until E advances.
  assign mduAccept = MduStartE && !StallE;

  // Keeps counting through memory stalls: the MDU runs independently of the
  // pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mduCnt <= '0;
    end else if (mduAccept) begin
      mduCnt <= MDU_LOAD;
    end else if (mduCnt != '0) begin
      mduCnt <= mduCnt - MCW'(1);
    end
  end

  assign MduBusy  = (mduCnt != '0);
  assign mduStall = (MduBusy || MduStartE) && (MduD || HiLoReadD);
`else
  logic [MCW+2:0] unusedMdu;
  assign unusedMdu = {MduStartE, MduD, HiLoReadD, MDU_LOAD};
  assign MduBusy   = 1'b0;
  assign mduStall  = 1'b0;
`endif

  logic [CNT_W-1:0] stallCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (StallF && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign StallCount = stallCnt;

endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;

  localparam int LAT     = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
  logic DmemReqM, DmemReadyM, MduStartE, MduD, HiLoReadD;
  logic [1:0] ForwardAE, ForwardBE, ForwardAD, ForwardBD;
  logic StallF, StallD, StallE, StallM, FlushE, FlushW, MduBusy;
  logic [CW-1:0] StallCount;

  hazard_sb #(.REG_AW(5), .MDU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM),
    .MduStartE(MduStartE), .MduD(MduD), .HiLoReadD(HiLoReadD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .MduBusy(MduBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Reference state: remaining MDU cycles and the stall-cycle tally.
  int mduRem  = 0;
  int cntModel = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] refFwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (RegWriteM && src == WriteRegM) return 2'b10;
    if (RegWriteW && src == WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  // Stall vector order: {StallF, StallD, StallE, StallM, FlushE, FlushW}
  task automatic refComb(output logic [7:0] f, output logic [5:0] s, output logic busy);
    logic ld, brs, ms, mds;
    busy = MDU_ON && (mduRem > 0);
    ld  = MemtoRegE && RtE != 0 && (RsD == RtE || RtD == RtE);
    brs = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                      (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
    ms  = DmemReqM && !DmemReadyM;
    mds = MDU_ON && (busy || MduStartE) && (MduD || HiLoReadD);
    if (ms)                     s = 6'b111101;
    else if (ld || brs || mds)  s = 6'b110010;
    else                        s = 6'b000000;
    f = {refFwd(RsE), refFwd(RtE), refFwd(RsD), refFwd(RtD)};
  endtask

  function automatic logic [7:0] dutFwd();
    return {ForwardAE, ForwardBE, ForwardAD, ForwardBD};
  endfunction

  function automatic logic [5:0] dutStall();
    return {StallF, StallD, StallE, StallM, FlushE, FlushW};
  endfunction

  // Called at posedge+1 with inputs already driven; compares, then advances
  // the reference across the next rising edge.
  task automatic cycle(input string nm);
    logic [7:0] f;
    logic [5:0] s;
    logic b;
    #2;
    refComb(f, s, b);
    chk({nm, ".fwd"}, dutFwd(), f);
    chk({nm, ".stall"}, dutStall(), s);
    chk({nm, ".busy"}, MduBusy, b);
    chk({nm, ".cnt"}, StallCount, cntModel);
    @(posedge clk);
    if (s[5] && cntModel < CNT_MAX) cntModel++;
    if (MDU_ON && MduStartE && !s[3]) mduRem = LAT;
    else if (mduRem > 0) mduRem--;
    #1;
  endtask

  task automatic doReset(input string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, ".rstBusy"}, MduBusy, 0);
    chk({nm, ".rstCnt"}, StallCount, 0);
    mduRem = 0;
    cntModel = 0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic setIdle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    DmemReqM = 0; DmemReadyM = 1;
    MduStartE = 0; MduD = 0; HiLoReadD = 0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic [2:0] rw;      // {RegWriteE, RegWriteM, RegWriteW}
    logic [1:0] m2r;     // {MemtoRegE, MemtoRegM}
    logic       br, req, rdy;
    logic [7:0] expFwd;  // {AE, BE, AD, BD}
    logic [5:0] expSt;
  } vec_t;

  function automatic vec_t mk(string n, logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW,
                              logic [2:0] rw, logic [1:0] m2r, logic br, req, rdy,
                              logic [7:0] ef, logic [5:0] es);
    vec_t v;
    v.name = n; v.rsD = rsD; v.rtD = rtD; v.rsE = rsE; v.rtE = rtE;
    v.wrE = wrE; v.wrM = wrM; v.wrW = wrW; v.rw = rw; v.m2r = m2r;
    v.br = br; v.req = req; v.rdy = rdy; v.expFwd = ef; v.expSt = es;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 rsD rtD rsE rtE wrE wrM wrW rw      m2r    br req rdy  fwd          stall
    vecs.push_back(mk("idle",      0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1, 8'b00000000, 6'b000000));
    vecs.push_back(mk("fwdAE_M",   0, 0, 3, 0, 0, 3, 3, 3'b011, 2'b00, 0, 0, 1, 8'b10000000, 6'b000000));
    vecs.push_back(mk("fwdAE_r0",  0, 0, 0, 0, 0, 3, 3, 3'b011, 2'b00, 0, 0, 1, 8'b00000000, 6'b000000));
    vecs.push_back(mk("fwdBE_W",   0, 0, 6, 5, 0, 5, 5, 3'b001, 2'b00, 0, 0, 1, 8'b00010000, 6'b000000));
    vecs.push_back(mk("loadStall", 7, 0, 0, 7, 0, 0, 0, 3'b000, 2'b10, 0, 0, 1, 8'b00000000, 6'b110010));
    vecs.push_back(mk("loadRtE0",  0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 0, 0, 1, 8'b00000000, 6'b000000));
    vecs.push_back(mk("branchE",   4, 0, 0, 0, 4, 0, 0, 3'b100, 2'b00, 1, 0, 1, 8'b00000000, 6'b110010));
    vecs.push_back(mk("branchE_r0",0, 0, 0, 0, 0, 0, 0, 3'b100, 2'b00, 1, 0, 1, 8'b00000000, 6'b000000));
    vecs.push_back(mk("branchM",   0, 9, 0, 0, 0, 9, 0, 3'b010, 2'b01, 1, 0, 1, 8'b00000010, 6'b110010));
    vecs.push_back(mk("branchNoWr",4, 0, 0, 0, 4, 0, 0, 3'b000, 2'b00, 1, 0, 1, 8'b00000000, 6'b000000));
    vecs.push_back(mk("memOverLd", 7, 0, 0, 7, 0, 0, 0, 3'b000, 2'b10, 0, 1, 0, 8'b00000000, 6'b111101));
    vecs.push_back(mk("memReady",  0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 1, 1, 8'b00000000, 6'b000000));
    vecs.push_back(mk("fwdAD_W",   8, 0, 0, 0, 0, 8, 8, 3'b001, 2'b00, 0, 0, 1, 8'b00000100, 6'b000000));

    setIdle();
    rst_n = 1'b0;
    #2;
    chk("reset.busy", MduBusy, 0);
    chk("reset.cnt", StallCount, 0);
    chk("reset.stall", dutStall(), 6'b000000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table vectors
    foreach (vecs[i]) begin
      setIdle();
      RsD = vecs[i].rsD; RtD = vecs[i].rtD; RsE = vecs[i].rsE; RtE = vecs[i].rtE;
      WriteRegE = vecs[i].wrE; WriteRegM = vecs[i].wrM; WriteRegW = vecs[i].wrW;
      {RegWriteE, RegWriteM, RegWriteW} = vecs[i].rw;
      {MemtoRegE, MemtoRegM} = vecs[i].m2r;
      BranchD = vecs[i].br; DmemReqM = vecs[i].req; DmemReadyM = vecs[i].rdy;
      #1;
      chk({vecs[i].name, ".tblFwd"}, dutFwd(), vecs[i].expFwd);
      chk({vecs[i].name, ".tblStall"}, dutStall(), vecs[i].expSt);
      cycle(vecs[i].name);
    end

    // Memory stall over a load-use stall for three cycles
    setIdle();
    doReset("memSeq");
    MemtoRegE = 1; RtE = 7; RsD = 7; DmemReqM = 1; DmemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("memSeq.stall", dutStall(), 6'b111101);
      cycle("memSeq");
    end
    setIdle();
    #1;
    chk("memSeq.count3", StallCount, 3);
    cycle("memSeqEnd");

    // MDU pulse: busy for exactly LAT cycles, HI/LO read stalls while busy
    doReset("mdu");
    MduStartE = 1;
    cycle("mduStart");
    MduStartE = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      HiLoReadD = (i == 1);
      #1;
      chk("mdu.busyWin", MduBusy, (MDU_ON && i < LAT) ? 1 : 0);
      if (i == 1) chk("mdu.hiloStall", {StallF, FlushE}, MDU_ON ? 2'b11 : 2'b00);
      cycle("mduBusy");
    end
    HiLoReadD = 0;

    // Start offered during a memory stall is held, then accepted
    DmemReqM = 1; DmemReadyM = 0; MduStartE = 1;
    cycle("mduHeld1");
    cycle("mduHeld2");
    #1;
    chk("mdu.heldNotBusy", MduBusy, 0);
    DmemReqM = 0; DmemReadyM = 1;
    cycle("mduAccept");
    MduStartE = 0;
    #1;
    chk("mdu.acceptedBusy", MduBusy, MDU_ON ? 1 : 0);
    cycle("mduAfter");

    // Reset in the second busy cycle aborts the operation
    doReset("mduAbortPre");
    MduStartE = 1;
    cycle("mduAbortStart");
    MduStartE = 0;
    cycle("mduAbortB1");
    #1;
    chk("mduAbort.busyBefore", MduBusy, MDU_ON ? 1 : 0);
    doReset("mduAbort");
    cycle("mduAbortAfter");

    // Saturation: 2^CW + 5 stalled cycles
    doReset("sat");
    DmemReqM = 1; DmemReadyM = 0;
    for (int i = 0; i < (1 << CW) + 5; i++) cycle("sat");
    #1;
    chk("sat.allOnes", StallCount, CNT_MAX);
    setIdle();
    cycle("satHold");

    // Randomized traffic against the reference
    doReset("rnd");
    for (int i = 0; i < 400; i++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0); MemtoRegM = ($urandom_range(0, 3) == 0);
      BranchD = ($urandom_range(0, 3) == 0);
      DmemReqM = 1'($urandom); DmemReadyM = ($urandom_range(0, 3) != 0);
      MduStartE = ($urandom_range(0, 7) == 0);
      MduD = ($urandom_range(0, 5) == 0); HiLoReadD = ($urandom_range(0, 5) == 0);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
